reg_dump_reader: RTL and testbench



---
 rtl/reg_dump_pkg.sv | 21 ++
 rtl/word_byte_serializer.sv | 63 ++++++
 rtl/reg_dump_reader.sv | 110 +++++++++++
 tb/tb_reg_dump_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the debug register-dump reader.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHaltWait,
    StHdr,
    StLatch,
    StSend,
    StDone
  } dump_state_e;

  localparam int unsigned XLEN_DEFAULT        = 32;
  localparam int unsigned BYTES_PER_REG       = XLEN_DEFAULT / 8;
  localparam logic [7:0]  HEADER_BYTE_DEFAULT = 8'hA5;

  function automatic int unsigned bytes_per_reg(input int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Loads one register word and emits it LSB-first as bytes behind a valid/ready stage.
module word_byte_serializer
  import reg_dump_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] word,
  input  logic            tx_ready,
  output logic [7:0]      byte_data,
  output logic            byte_valid,
  output logic            last_accepted
);

  localparam int unsigned Bytes = bytes_per_reg(XLEN);
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Bytes - 1);

  logic [XLEN-1:0] shift_q, shift_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic            valid_q, valid_d;
  logic            accept;

  assign accept = valid_q & tx_ready;

  always_comb begin
    shift_d       = shift_q;
    byte_cnt_d    = byte_cnt_q;
    valid_d       = valid_q;
    last_accepted = accept && (byte_cnt_q == LastCnt);
    if (load) begin
      shift_d    = word;
      byte_cnt_d = '0;
      valid_d    = 1'b1;
    end else if (accept) begin
      if (byte_cnt_q == LastCnt) begin
        valid_d = 1'b0;
      end else begin
        shift_d    = shift_q >> 8;
        byte_cnt_d = byte_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Data is forced to zero when idle so stale bytes never leak onto the bus.
  assign byte_valid = valid_q;
  assign byte_data  = valid_q ? shift_q[7:0] : 8'h00;

endmodule

// File: rtl/reg_dump_reader.sv
// Halts the core, walks the register file and streams it out as bytes (optional header first).
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter bit          SEND_HEADER = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dump_start,
  output logic            core_halt_req,
  input  logic            core_halted,
  output logic [4:0]      rf_read_address,
  input  logic [XLEN-1:0] rf_read_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            done
);

  localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

  dump_state_e state_q, state_d;
  logic [4:0]  reg_idx_q, reg_idx_d;
  logic        halt_q, halt_d;
  logic        load;
  logic        ser_valid;
  logic        last_accepted;
  logic [7:0]  ser_data;

  always_comb begin
    state_d   = state_q;
    reg_idx_d = reg_idx_q;
    halt_d    = halt_q;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StHaltWait;
          halt_d  = 1'b1;
        end
      end
      StHaltWait: begin
        if (core_halted) begin
          reg_idx_d = '0;
          state_d   = SEND_HEADER ? StHdr : StLatch;
        end
      end
      StHdr: begin
        if (tx_ready) state_d = StLatch;
      end
      StLatch: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (last_accepted) begin
          if (reg_idx_q == LastIdx) begin
            state_d = StDone;
            halt_d  = 1'b0;
          end else begin
            reg_idx_d = reg_idx_q + 5'd1;
            state_d   = StLatch;
          end
        end
      end
      StDone: begin
        reg_idx_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      reg_idx_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
      halt_q    <= halt_d;
    end
  end

  word_byte_serializer #(
    .XLEN (XLEN)
  ) u_serializer (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .word          (rf_read_data),
    .tx_ready      (tx_ready),
    .byte_data     (ser_data),
    .byte_valid    (ser_valid),
    .last_accepted (last_accepted)
  );

  assign tx_valid        = (state_q == StHdr) | ser_valid;
  assign tx_data         = (state_q == StHdr) ? HEADER_BYTE : ser_data;
  assign rf_read_address = reg_idx_q;
  assign core_halt_req   = halt_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: default instance plus a 4-register, headerless instance.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dump_start = 1'b0;
  logic        core_halt_req;
  logic        core_halted;
  logic [4:0]  rf_read_address;
  logic [31:0] rf_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  logic        dump_start_b = 1'b0;
  logic        core_halt_req_b;
  logic [4:0]  rf_read_address_b;
  logic [31:0] rf_read_data_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b;
  logic        busy_b;
  logic        done_b;

  logic [31:0] rf [32];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_qb[$];
  logic [7:0]  got_qb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int start_cyc_b = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_cnt_b = 0;
  int done_cyc_b = 0;
  int ack_delay = 1;
  int halt_cnt = 0;
  logic halted_q = 1'b0;
  logic ready_rand = 1'b0;
  logic ready_block = 1'b0;
  logic stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_read_data   = rf[rf_read_address];
  assign rf_read_data_b = rf[rf_read_address_b];

  // Core model: acknowledges the halt ack_delay cycles after the request (0 = always halted).
  always @(posedge clk) begin
    if (reset || !core_halt_req) begin
      halt_cnt <= 0;
      halted_q <= 1'b0;
    end else begin
      halt_cnt <= halt_cnt + 1;
      halted_q <= (halt_cnt + 1 >= ack_delay);
    end
  end
  assign core_halted = (ack_delay == 0) ? 1'b1 : halted_q;

  reg_dump_reader u_dut (
    .clk             (clk),
    .reset           (reset),
    .dump_start      (dump_start),
    .core_halt_req   (core_halt_req),
    .core_halted     (core_halted),
    .rf_read_address (rf_read_address),
    .rf_read_data    (rf_read_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .done            (done)
  );

  reg_dump_reader #(
    .NUM_REGS    (4),
    .SEND_HEADER (1'b0)
  ) u_dut_b (
    .clk             (clk),
    .reset           (reset),
    .dump_start      (dump_start_b),
    .core_halt_req   (core_halt_req_b),
    .core_halted     (1'b1),
    .rf_read_address (rf_read_address_b),
    .rf_read_data    (rf_read_data_b),
    .tx_data         (tx_data_b),
    .tx_valid        (tx_valid_b),
    .tx_ready        (1'b1),
    .busy            (busy_b),
    .done            (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor for the default instance: drive ready, check holds on stalls, score accepted bytes.
  always @(negedge clk) begin
    tx_ready = ready_block ? 1'b0 : (ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    #1;
    if (stall_q) begin
      check("hold_valid", tx_valid, 1'b1);
      check("hold_data", tx_data, stall_data);
    end
    stall_q    = tx_valid && !tx_ready && !reset;
    stall_data = tx_data;
    if (tx_valid && tx_ready && !reset) begin
      got_q.push_back(tx_data);
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("byte", tx_data, exp_q.pop_front());
    end
    if (done && !reset) begin
      done_cnt++;
      done_cyc = cyc - start_cyc + 1;
      check("halt_req_in_done", core_halt_req, 1'b0);
    end
  end

  always @(negedge clk) begin
    #1;
    if (tx_valid_b && !reset) begin
      got_qb.push_back(tx_data_b);
      check("b_sb_nonempty", exp_qb.size() != 0, 1'b1);
      if (exp_qb.size() != 0) check("b_byte", tx_data_b, exp_qb.pop_front());
    end
    if (done_b && !reset) begin
      done_cnt_b++;
      done_cyc_b = cyc - start_cyc_b + 1;
    end
  end

  task automatic start_a();
    exp_q.delete();
    got_q.delete();
    done_cnt = 0;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 32; k++)
      for (int j = 0; j < 4; j++) exp_q.push_back(rf[k][8*j +: 8]);
    @(negedge clk);
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    dump_start = 1'b0;
  endtask

  task automatic finish_a(input int exp_cyc);
    int i = 0;
    while (done_cnt == 0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #3;
    check("done_count", done_cnt, 1);
    if (exp_cyc != 0) check("done_cycle", done_cyc, exp_cyc);
    check("byte_count", got_q.size(), 129);
    check("sb_drained", exp_q.size(), 0);
    check("halt_req_idle", core_halt_req, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + k;

    repeat (3) @(posedge clk);
    #3;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_halt_req", core_halt_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", rf_read_address, 5'd0);
    reset = 1'b0;

    // Baseline: halt ack one cycle after request adds one HALT_WAIT cycle to 163.
    ack_delay = 1;
    start_a();
    finish_a(164);

    // Latency case: core already halted in cycle 1.
    ack_delay = 0;
    start_a();
    finish_a(163);

    // Delayed ack: nothing transmitted while waiting, stream shifted by 10 cycles.
    ack_delay = 10;
    start_a();
    for (int c = 0; c < 10; c++) begin
      check("wait_no_valid", tx_valid, 1'b0);
      check("wait_busy", busy, 1'b1);
      @(posedge clk);
      #1;
    end
    finish_a(173);

    // Random backpressure with a distinctive word in r5.
    ack_delay  = 1;
    rf[5]      = 32'hDEADBEEF;
    ready_rand = 1'b1;
    start_a();
    finish_a(0);
    ready_rand = 1'b0;
    if (got_q.size() >= 25) begin
      check("r5_b0", got_q[21], 8'hEF);
      check("r5_b1", got_q[22], 8'hBE);
      check("r5_b2", got_q[23], 8'hAD);
      check("r5_b3", got_q[24], 8'hDE);
    end else begin
      check("r5_present", got_q.size(), 129);
    end
    rf[5] = 32'h1000_0005;

    // Second dump_start during SEND must be ignored.
    start_a();
    repeat (20) @(posedge clk);
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    finish_a(164);
    repeat (5) @(posedge clk);
    #3;
    check("no_restart", busy, 1'b0);

    // Reset while r10 byte 2 is on the bus (stream position 43).
    start_a();
    for (int i = 0; i < 500 && got_q.size() != 43; i++) begin
      @(posedge clk);
      #3;
    end
    check("reached_r10", got_q.size(), 43);
    check("r10_addr", rf_read_address, 5'd10);
    ready_block = 1'b1;
    reset       = 1'b1;
    @(posedge clk);
    #3;
    check("mid_rst_valid", tx_valid, 1'b0);
    check("mid_rst_halt", core_halt_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", rf_read_address, 5'd0);
    reset       = 1'b0;
    ready_block = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("no_done_on_reset", done_cnt, 0);
    start_a();
    finish_a(164);

    // Headerless 4-register instance: 16 bytes, DONE one cycle after the last SEND (cycle 22).
    exp_qb.delete();
    got_qb.delete();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) exp_qb.push_back(rf[k][8*j +: 8]);
    @(negedge clk);
    dump_start_b = 1'b1;
    @(posedge clk);
    #1;
    start_cyc_b  = cyc;
    dump_start_b = 1'b0;
    for (int i = 0; i < 200 && done_cnt_b == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    check("b_done_count", done_cnt_b, 1);
    check("b_done_cycle", done_cyc_b, 22);
    check("b_byte_count", got_qb.size(), 16);
    check("b_sb_drained", exp_qb.size(), 0);
    if (got_qb.size() != 0) check("b_no_header", got_qb[0], 8'h00);
    check("b_halt_idle", core_halt_req_b, 1'b0);
    check("b_busy_idle", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
